// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// even/odd parity bit, one stop bit. All outputs are registered.
module uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic baud_end;
  logic par_bit;

  assign baud_end = (baud_q == BAUD_LAST);
  assign par_bit  = (^data_q) ^ par_typ_q;

  // Next-state and next-output logic; tx_d is the line value for the coming cycle.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (Data_Valid) begin
          state_d   = START;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = data_q[0];
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
            tx_d  = data_q[bit_d];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TX_OUT  = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, DATA_WIDTH=8; outputs are
// sampled and inputs driven on the falling clock edge.
module tb_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned DW  = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          busy;
  logic          tx_done;

  int n_cmp;
  int n_err;

  uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Sends one frame starting at the current falling edge and checks every line
  // cycle. hold keeps Data_Valid high and switches P_DATA to d_next after
  // acceptance; pulse pokes Data_Valid during START, data bit 3 and STOP.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic ptyp, input logic exp_par, input bit hold,
                           input bit pulse, input logic [7:0] d_next);
    int   nbits;
    int   busy_n;
    int   done_n;
    logic e;
    nbits  = 10 + int'(pen);
    busy_n = 0;
    done_n = 0;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    @(negedge clk);
    P_DATA  = hold ? d_next : ~d;
    PAR_EN  = ~pen;
    PAR_TYP = ~ptyp;
    if (!hold) Data_Valid = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        if (i == 0)                 e = 1'b0;
        else if (i <= 8)            e = d[i-1];
        else if (pen && i == 9)     e = exp_par;
        else                        e = 1'b1;
        chk($sformatf("%s.tx[b%0d c%0d]", tag, i, c), 32'(TX_OUT), 32'(e));
        busy_n += int'(busy);
        done_n += int'(tx_done);
        if (pulse)
          Data_Valid = (c == 2) && (i == 0 || i == 4 || i == nbits - 1);
        @(negedge clk);
      end
    end
    chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(nbits * int'(CPB)));
    chk({tag, ".early_done"}, 32'(done_n), 32'd0);
    chk({tag, ".done_end"}, 32'(tx_done), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".tx_end"}, 32'(TX_OUT), 32'd1);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b0;
    Data_Valid = 1'b1;
    P_DATA     = 8'h5A;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.tx", 32'(TX_OUT), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(tx_done), 32'd0);

    // First acceptance on the first edge with reset released.
    rst = 1'b1;
    run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("a5_nopar.done_1cyc", 32'(tx_done), 32'd0);
    chk("a5_nopar.idle_tx", 32'(TX_OUT), 32'd1);

    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    run_frame("00_odd", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    run_frame("ff_odd", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Back-to-back: second start bit follows one idle-high cycle after tx_done.
    run_frame("hold1", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC1);
    run_frame("hold2", 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Data_Valid pulses mid-frame are ignored.
    run_frame("pulse", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    Data_Valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("pulse.no_extra_busy", 32'(busy), 32'd0);
      chk("pulse.no_extra_tx", 32'(TX_OUT), 32'd1);
    end

    // Reset during data bit 3 aborts the frame.
    P_DATA     = 8'hE7;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    repeat (4 * CPB + 1) @(negedge clk);
    chk("abort.pre_tx_bit3", 32'(TX_OUT), 32'd0);
    chk("abort.pre_busy", 32'(busy), 32'd1);
    rst        = 1'b0;
    Data_Valid = 1'b1;
    @(negedge clk);
    chk("abort.tx", 32'(TX_OUT), 32'd1);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(tx_done), 32'd0);
    @(negedge clk);
    chk("abort.dv_ignored", 32'(busy), 32'd0);
    chk("abort.no_done", 32'(tx_done), 32'd0);
    rst = 1'b1;
    run_frame("after_rst", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit period; legal range 2..1024.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-low.
REQ-005 Port P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled only at acceptance.
REQ-006 Port Data_Valid  input  1  request to transmit P_DATA.
REQ-007 Port PAR_EN  input  1  1 = insert a parity bit; sampled at acceptance.
REQ-008 Port PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled at acceptance.
REQ-009 Port TX_OUT  output  1  serial line, idle high, registered.
REQ-010 Port busy  output  1  high while a frame is on the line, registered.
REQ-011 Port tx_done  output  1  one-cycle pulse marking frame completion, registered.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP; encoding is free.
REQ-013 Acceptance occurs on a rising edge with state=IDLE and Data_Valid=1.
REQ-014 At acceptance: P_DATA, PAR_EN and PAR_TYP are latched; later changes to these inputs do not affect the frame.
REQ-015 Data_Valid in any state other than IDLE is ignored; there is no queueing or back-pressure beyond busy.
REQ-016 Acceptance at edge T0 puts state=START, TX_OUT=0 and busy=1 from T0 onward, for exactly CLKS_PER_BIT cycles.
REQ-017 Each bit period is timed by a baud counter that counts 0..CLKS_PER_BIT-1, then clears and advances the bit.
REQ-018 Counter width is clog2(CLKS_PER_BIT).
REQ-019 DATA: transmits DATA_WIDTH bits LSB first, each for CLKS_PER_BIT cycles, using a bit counter 0..DATA_WIDTH-1.
REQ-020 After the last data bit: next state is PARITY if the latched PAR_EN=1, else STOP.
REQ-021 PARITY bit value is the XOR of the latched data, inverted if the latched PAR_TYP=1; it lasts CLKS_PER_BIT cycles.
REQ-022 STOP: TX_OUT=1 for CLKS_PER_BIT cycles.
REQ-023 On the edge ending STOP: state returns to IDLE, busy returns to 0, and tx_done is 1 for exactly one cycle.
REQ-024 busy stays high for exactly (2+DATA_WIDTH+PAR_EN)*CLKS_PER_BIT cycles per frame.
REQ-025 A new frame can be accepted on the first IDLE cycle. The line then stays high for exactly one extra cycle before the next start bit, which is the minimum inter-frame gap.
REQ-026 In IDLE: TX_OUT=1 and the baud and bit counters are held at 0.
REQ-027 An unreachable or illegal state encoding returns to IDLE on the next edge with TX_OUT=1.
REQ-028 TX_OUT has no combinational path from any input; it changes only on clk edges.

Reset
REQ-029 While rst=0 at a rising edge: state=IDLE, TX_OUT=1, busy=0, tx_done=0, and the counters and data latch are cleared.
REQ-030 Reset asserted mid-frame aborts the frame immediately at that edge: the line returns high with no tx_done pulse, and Data_Valid is ignored while rst=0.
REQ-031 The first acceptance is possible on the first edge with rst=1.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-032 Scenario: P_DATA=0xA5, PAR_EN=0, single-cycle Data_Valid. Required: TX_OUT per 4-cycle bit = 0, 1,0,1,0,0,1,0,1, 1; busy high for 40 cycles; tx_done pulses once at the end.
REQ-033 Scenario: 0xA5 with PAR_EN=1, PAR_TYP=0, then with PAR_TYP=1. Required: parity bit 0 for the first frame and 1 for the second; busy high for 44 cycles each.
REQ-034 Scenario: Data_Valid held high continuously with P_DATA changed mid-frame. Required: the first frame carries the originally latched value, and the next start bit follows exactly one high IDLE cycle after tx_done.
REQ-035 Scenario: rst driven low during data bit 3. Required: TX_OUT=1 and busy=0 at that edge; no tx_done; a frame accepted after release is transmitted correctly from its start bit.
REQ-036 Scenario: P_DATA=0x00 and P_DATA=0xFF with odd parity. Required: parity bits 1 and 1 respectively; stop bit high; busy counts exact.
REQ-037 Scenario: Data_Valid pulses during START, DATA and STOP. Required: all pulses ignored; no extra frames and no change to the in-flight bits.
